// File: rtl/pc_predict.sv
// Fetch PC stage with a direct-mapped BTB and 2-bit saturating predictors; next pc_o one cycle after each edge.
// stall0 holds pc_o, br overrides stall0, and training writes are independent of both.
module pc_predict #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BTB_DEPTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall0,
  input  logic                  br,
  input  logic [ADDR_WIDTH-1:0] br_addr,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_target_o
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [BTB_DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
  logic [TAG_W-1:0]      tag_d    [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] target_d [BTB_DEPTH];
  logic [1:0]            ctr_q    [BTB_DEPTH];
  logic [1:0]            ctr_d    [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             unused_lsbs;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[ADDR_WIDTH-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign unused_lsbs = ^upd_pc[1:0];

  // Lookup reads registered state only, so a same-cycle training write is not bypassed.
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : pc_q + ADDR_WIDTH'(4);
  assign pc_o          = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (br) begin
      pc_d = br_addr;
    end else if (!stall0) begin
      pc_d = pred_target_o;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          ctr_d[up_idx]    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
          target_d[up_idx] = upd_target;
        end else begin
          ctr_d[up_idx] = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever aliases to this index; starts weakly taken.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict at default parameters (32-bit, 16 entries, RESET_PC=0).
module tb_pc_predict;
  logic        clock = 1'b0;
  logic        reset, stall0, br, upd_valid, upd_taken;
  logic [31:0] br_addr, upd_pc, upd_target;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o;
  int checks = 0;
  int failures = 0;

  pc_predict dut (
    .clock(clock), .reset(reset), .stall0(stall0), .br(br), .br_addr(br_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; upd_valid = 1'b0; br = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] a);
    br = 1'b1; br_addr = a;
    tick();
    br = 1'b0;
  endtask

  task automatic train(input logic [31:0] p, input logic t, input logic [31:0] tg);
    upd_valid = 1'b1; upd_pc = p; upd_taken = t; upd_target = tg;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    reset = 1'b0; stall0 = 1'b0; br = 1'b0; br_addr = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    tick(); tick();
    checks++;
    if (pc_o !== 32'h0 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h4) begin
      failures++;
      $display("FAIL reset_state pc=%h pt=%b tgt=%h exp pc=0 pt=0 tgt=4", pc_o, pred_taken_o, pred_target_o);
    end
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'(4 * i);
      checks++;
      if (pc_o !== exp_pc || pred_taken_o !== 1'b0) begin
        failures++;
        $display("FAIL seq_run step=%0d pc=%h pt=%b exp pc=%h pt=0", i, pc_o, pred_taken_o, exp_pc);
      end
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    tick(); tick();
    stall0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_o !== 32'h8 || pred_target_o !== 32'hC) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d pc=%h tgt=%h exp pc=8 tgt=c", i, pc_o, pred_target_o);
      end
    end
    redirect(32'h100);
    checks++;
    if (pc_o !== 32'h100) begin
      failures++;
      $display("FAIL br_over_stall pc=%h exp=100", pc_o);
    end
    stall0 = 1'b0;
    tick();
    checks++;
    if (pc_o !== 32'h104) begin
      failures++;
      $display("FAIL after_br pc=%h exp=104", pc_o);
    end
    stall0 = 1'b1;
    redirect(32'hFFFF_FFFC);
    checks++;
    if (pred_target_o !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap tgt=%h exp=0", pred_target_o);
    end
  endtask

  task automatic test_alloc_predict();
    logic [31:0] exp_seq [7];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h80, 32'h84};
    do_reset();
    stall0 = 1'b1;
    train(32'h10, 1'b1, 32'h80);
    stall0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (pc_o !== exp_seq[i]) begin
        failures++;
        $display("FAIL alloc_seq step=%0d pc=%h exp=%h", i, pc_o, exp_seq[i]);
      end
      if (i == 4) begin
        checks++;
        if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin
          failures++;
          $display("FAIL alloc_pred pt=%b tgt=%h exp pt=1 tgt=80", pred_taken_o, pred_target_o);
        end
      end
      if (i < 6) tick();
    end
  endtask

  task automatic test_hysteresis();
    // Entry at 0x10 enters with ctr=2 from the previous test.
    stall0 = 1'b1;
    redirect(32'h10);
    train(32'h10, 1'b0, 32'h0);
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h14) begin
      failures++;
      $display("FAIL hyst_nt1 pt=%b tgt=%h exp pt=0 tgt=14", pred_taken_o, pred_target_o);
    end
    train(32'h10, 1'b1, 32'hC0);
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'hC0) begin
      failures++;
      $display("FAIL hyst_t_retarget pt=%b tgt=%h exp pt=1 tgt=c0", pred_taken_o, pred_target_o);
    end
    train(32'h10, 1'b1, 32'hC0);
    train(32'h10, 1'b1, 32'hC0);
    train(32'h10, 1'b0, 32'h0);
    checks++;
    if (pred_taken_o !== 1'b1) begin
      failures++;
      $display("FAIL sat_high pt=%b exp=1", pred_taken_o);
    end
    train(32'h10, 1'b0, 32'h0);
    checks++;
    if (pred_taken_o !== 1'b0) begin
      failures++;
      $display("FAIL ctr_dec pt=%b exp=0", pred_taken_o);
    end
    train(32'h10, 1'b0, 32'h0);
    train(32'h10, 1'b0, 32'h0);
    train(32'h10, 1'b1, 32'hC0);
    checks++;
    if (pred_taken_o !== 1'b0) begin
      failures++;
      $display("FAIL sat_low pt=%b exp=0", pred_taken_o);
    end
  endtask

  task automatic test_aliasing();
    do_reset();
    stall0 = 1'b1;
    train(32'h10, 1'b1, 32'h80);
    train(32'h50, 1'b1, 32'h300);
    redirect(32'h10);
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h14) begin
      failures++;
      $display("FAIL alias_evict pt=%b tgt=%h exp pt=0 tgt=14", pred_taken_o, pred_target_o);
    end
    redirect(32'h50);
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h300) begin
      failures++;
      $display("FAIL alias_hit pt=%b tgt=%h exp pt=1 tgt=300", pred_taken_o, pred_target_o);
    end
    train(32'h90, 1'b0, 32'h900);
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h300) begin
      failures++;
      $display("FAIL alias_nt_miss pt=%b tgt=%h exp pt=1 tgt=300", pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    stall0 = 1'b1;
    redirect(32'h20);
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h400;
    #1;
    checks++;
    if (pred_taken_o !== 1'b0) begin
      failures++;
      $display("FAIL collide_same_cycle pt=%b exp=0", pred_taken_o);
    end
    tick();
    upd_valid = 1'b0;
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h400) begin
      failures++;
      $display("FAIL collide_next pt=%b tgt=%h exp pt=1 tgt=400", pred_taken_o, pred_target_o);
    end
    // Redirect and training together both land.
    br = 1'b1; br_addr = 32'h60;
    upd_valid = 1'b1; upd_pc = 32'h60; upd_taken = 1'b1; upd_target = 32'h700;
    tick();
    br = 1'b0; upd_valid = 1'b0;
    checks++;
    if (pc_o !== 32'h60 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h700) begin
      failures++;
      $display("FAIL br_and_train pc=%h pt=%b tgt=%h exp pc=60 pt=1 tgt=700", pc_o, pred_taken_o, pred_target_o);
    end
    reset = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1; upd_target = 32'h500;
    tick();
    reset = 1'b1; upd_valid = 1'b0;
    checks++;
    if (pc_o !== 32'h0 || pred_taken_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid pc=%h pt=%b exp pc=0 pt=0", pc_o, pred_taken_o);
    end
    redirect(32'h30);
    checks++;
    if (pred_taken_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_train pt=%b exp=0", pred_taken_o);
    end
    redirect(32'h20);
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h24) begin
      failures++;
      $display("FAIL reset_clears pt=%b tgt=%h exp pt=0 tgt=24", pred_taken_o, pred_target_o);
    end
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_alloc_predict();
    test_hysteresis();
    test_aliasing();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_predict.md
# pc_predict

Parametrised program-counter stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. It sits at the front of the fetch pipeline and supplies the next fetch address every cycle. It honours the stall from the fetch/cache side and the redirect from execute. Execute also trains it with resolved branch outcomes, so taken branches are predicted without waiting for resolution.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of all addresses.
- BTB_DEPTH, 16, number of BTB entries; power of two, at least 2.
- RESET_PC, 0, value loaded into pc_o on reset.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low: state clears on a posedge where reset==0.
- stall0  input  1  hold pc_o (fetch not accepting).
- br  input  1  redirect from execute (mispredict/jump); overrides stall0.
- br_addr  input  ADDR_WIDTH  redirect target.
- upd_valid  input  1  resolved branch training strobe.
- upd_pc  input  ADDR_WIDTH  address of the resolved branch.
- upd_taken  input  1  resolved direction.
- upd_target  input  ADDR_WIDTH  resolved target.
- pc_o  output  ADDR_WIDTH  current fetch address.
- pred_taken_o  output  1  prediction for pc_o (combinational from the table and pc_o).
- pred_target_o  output  ADDR_WIDTH  predicted next address for pc_o.

## Operation
- IDX_W = log2(BTB_DEPTH).
  - Index: pc[IDX_W+1:2].
  - Tag: pc[ADDR_WIDTH-1:IDX_W+2].
  - Bits [1:0] are ignored for lookup.
- Each entry holds: valid, tag, target (ADDR_WIDTH), ctr (2 bits).
- Lookup (combinational on pc_o):
  - hit = valid && tag match.
  - pred_taken_o = hit && ctr[1].
  - pred_target_o = pred_taken_o ? entry.target : pc_o + 4.
  - The add wraps modulo 2^ADDR_WIDTH.
- Next pc_o, in priority order:
  1. reset==0 → RESET_PC.
  2. br → br_addr.
  3. !stall0 → pred_target_o.
  4. Otherwise hold.
- Training, on a posedge with upd_valid=1 and reset=1, at the index of upd_pc:
  - Entry hit and upd_taken: ctr = min(ctr+1, 3); target = upd_target.
  - Entry hit and !upd_taken: ctr = max(ctr-1, 0); target unchanged; valid stays 1.
  - Miss and upd_taken: allocate, overwriting any entry. valid=1, tag = upd_pc tag, target = upd_target, ctr = 2'b10.
  - Miss and !upd_taken: no change.
- Training and redirect are independent. Both may occur in the same cycle and both take effect.

## Timing
- Reset (reset==0 at a posedge):
  - pc_o = RESET_PC.
  - All valid bits = 0; ctr and target of every entry = 0.
  - Hence pred_taken_o = 0 and pred_target_o = RESET_PC+4 from the next cycle.
  - Reset mid-operation discards any training applied in that same cycle.
- pc_o latency: br_addr or prediction appears on pc_o one cycle after the edge. No bubble is inserted.
- Training latency: the update becomes visible to lookup on the cycle after the edge. When training and lookup hit the same index in the same cycle, lookup sees the old contents (no bypass).
- br while stall0=1: pc_o still takes br_addr.
- stall0=1 with no br: pc_o, pred_taken_o and pred_target_o stay stable. Outputs may change only if training modified the looked-up entry.
- Aliasing: two PCs with the same index and different tags evict each other. No associativity.
- Counter saturation: ctr never wraps past 3 or below 0.

## Test plan
- **Reset and sequential run:** hold reset=0 for 2 cycles, then release with stall0=0, br=0, RESET_PC=0 → pc_o runs 0, 4, 8, 12; pred_taken_o=0 throughout.
- **Stall and redirect priority:** at pc_o=8, stall0=1 for 3 cycles → pc_o holds 8. Then stall0=1 with br=1, br_addr=0x100 → pc_o=0x100 next cycle.
- **Allocation and prediction:** upd_valid with upd_pc=0x10, taken, target=0x80; then run from 0 → pc_o sequence 0, 4, 8, 0xC, 0x10, 0x80, 0x84.
- **Counter hysteresis:** entry at 0x10 with ctr=2. Train not-taken once → still allocated, ctr=1, pred_taken_o=0 at 0x10. Train taken twice → ctr=3. Train not-taken once → still predicts taken.
- **Aliasing (BTB_DEPTH=16):** allocate 0x10, then allocate 0x50 (same index, different tag) → lookup at 0x10 misses, at 0x50 hits. Not-taken training on 0x90 leaves the entry unchanged.
- **Same-cycle collision and reset:** train 0x20 while pc_o=0x20 → pred_taken_o=0 that cycle and 1 the next. Reset asserted with upd_valid=1 → entry not allocated and pc_o=RESET_PC.
